inst_encoder_loader: RTL and testbench

Instruction encoder and loader for the single-cycle RV32I core's instruction memory: the inverse of the immediate decode path. Accepts decoded instruction fields (opcode, registers, funct, full 32-bit immediate) over a valid/ready handshake. Range-checks the immediate and scatters its bits into R/I/S/B/J format. Writes the encoded word to the next sequential instruction-memory address over a write/ack port. Used by the testbench and boot path to build programs without a precompiled hex file.

---
 rtl/inst_encoder_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_inst_encoder_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_loader.sv
// RV32I instruction encoder/loader: takes decoded fields, range-checks the immediate,
// packs it into R/I/S/B/J format and writes it to sequential instruction-memory words.
module inst_encoder_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [31:0]           mem_wr_data,
    input  logic                  mem_wr_ack,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [ADDR_WIDTH:0]   inst_count,
    output logic                  full
);

    localparam logic [6:0] OpArith    = 7'b0110011;
    localparam logic [6:0] OpArithImm = 7'b0010011;
    localparam logic [6:0] OpLoad     = 7'b0000011;
    localparam logic [6:0] OpJalr     = 7'b1100111;
    localparam logic [6:0] OpStore    = 7'b0100011;
    localparam logic [6:0] OpBranch   = 7'b1100011;
    localparam logic [6:0] OpJal      = 7'b1101111;
    localparam logic [6:0] OpEcall    = 7'b1110011;

    localparam logic [1:0] ErrNone   = 2'd0;
    localparam logic [1:0] ErrOpcode = 2'd1;
    localparam logic [1:0] ErrRange  = 2'd2;
    localparam logic [1:0] ErrOdd    = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] AddrMax  = '1;
    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CountOne = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {StIdle, StEnc, StWr} state_e;

    state_e                state_q, state_d;
    logic [6:0]            op_q, op_d;
    logic [4:0]            rd_q, rd_d;
    logic [4:0]            rs1_q, rs1_d;
    logic [4:0]            rs2_q, rs2_d;
    logic [2:0]            f3_q, f3_d;
    logic [6:0]            f7_q, f7_d;
    logic [31:0]           imm_q, imm_d;
    logic [31:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;

    logic signed [31:0] imm_s;
    logic               imm12_bad, shamt_bad, b_bad, j_bad, is_shift;
    logic [31:0]        enc_word;
    logic [1:0]         enc_err;

    // Range checks are signed compares on the full 32-bit immediate
    always_comb begin
        imm_s     = imm_q;
        imm12_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
        shamt_bad = (imm_s < 32'sd0) || (imm_s > 32'sd31);
        b_bad     = (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
        j_bad     = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574);
        is_shift  = (f3_q == 3'b001) || (f3_q == 3'b101);
    end

    always_comb begin
        enc_word = '0;
        enc_err  = ErrNone;
        case (op_q)
            OpArith: enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
            OpArithImm: begin
                if (is_shift) begin
                    enc_word = {f7_q, imm_q[4:0], rs1_q, f3_q, rd_q, op_q};
                    if (shamt_bad) enc_err = ErrRange;
                end else begin
                    enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
                    if (imm12_bad) enc_err = ErrRange;
                end
            end
            OpLoad, OpJalr: begin
                enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
                if (imm12_bad) enc_err = ErrRange;
            end
            OpStore: begin
                enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
                if (imm12_bad) enc_err = ErrRange;
            end
            OpBranch: begin
                enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11],
                            op_q};
                if (imm_q[0])   enc_err = ErrOdd;
                else if (b_bad) enc_err = ErrRange;
            end
            OpJal: begin
                enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
                if (imm_q[0])   enc_err = ErrOdd;
                else if (j_bad) enc_err = ErrRange;
            end
            OpEcall: enc_word = 32'h0000_0073;
            default: enc_err = ErrOpcode;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        f3_d       = f3_q;
        f7_d       = f7_q;
        imm_d      = imm_q;
        data_d     = data_q;
        addr_d     = addr_q;
        count_d    = count_q;
        full_d     = full_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        if (restart) begin
            // Drops any in-flight instruction; err_code deliberately survives
            state_d = StIdle;
            addr_d  = BaseAddr;
            count_d = '0;
            full_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && !full_q) begin
                        op_d    = in_opcode;
                        rd_d    = in_rd;
                        rs1_d   = in_rs1;
                        rs2_d   = in_rs2;
                        f3_d    = in_funct3;
                        f7_d    = in_funct7;
                        imm_d   = in_imm;
                        state_d = StEnc;
                    end
                end
                StEnc: begin
                    if (enc_err != ErrNone) begin
                        err_d      = 1'b1;
                        err_code_d = enc_err;
                        state_d    = StIdle;
                    end else begin
                        data_d  = enc_word;
                        state_d = StWr;
                    end
                end
                StWr: begin
                    if (mem_wr_ack) begin
                        count_d = count_q + CountOne;
                        if (addr_q == AddrMax) full_d = 1'b1;
                        else                   addr_d = addr_q + AddrOne;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            f3_q       <= '0;
            f7_q       <= '0;
            imm_q      <= '0;
            data_q     <= '0;
            addr_q     <= BaseAddr;
            count_q    <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            f3_q       <= f3_d;
            f7_q       <= f7_d;
            imm_q      <= imm_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign in_ready    = (state_q == StIdle) && !full_q;
    assign mem_wr_en   = (state_q == StWr);
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign inst_count  = count_q;
    assign full        = full_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: directed cases plus randomized instructions
// checked against an arithmetic reference encoder; a 2-bit-address copy exercises full.
module tb_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        reset, restart, in_valid, mem_wr_ack;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;

    logic        in_ready, mem_wr_en, err, full;
    logic [9:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [1:0]  err_code;
    logic [10:0] inst_count;

    logic        s_in_ready, s_mem_wr_en, s_err, s_full;
    logic [1:0]  s_mem_wr_addr;
    logic [31:0] s_mem_wr_data;
    logic [1:0]  s_err_code;
    logic [2:0]  s_inst_count;

    int vectors = 0;
    int miscompares = 0;
    int m_addr, m_count, m_err_code;
    bit m_full;

    always #5 clk = ~clk;

    inst_encoder_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack), .err(err), .err_code(err_code), .inst_count(inst_count),
        .full(full)
    );

    inst_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .reset(reset), .restart(restart), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .mem_wr_en(s_mem_wr_en), .mem_wr_addr(s_mem_wr_addr), .mem_wr_data(s_mem_wr_data),
        .mem_wr_ack(mem_wr_ack), .err(s_err), .err_code(s_err_code),
        .inst_count(s_inst_count), .full(s_full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from field weights and immediate bit extraction
    function automatic void model_enc(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] imm, output int code,
                                      output logic [31:0] word);
        int v;
        logic [31:0] base;
        v    = imm;
        code = 0;
        word = 32'd0;
        base = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
        case (op)
            7'h33: word = base | (32'(rs2) << 20) | (32'(f7) << 25);
            7'h13, 7'h03, 7'h67: begin
                if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                    if (v < 0 || v > 31) code = 2;
                    word = base | (32'(v & 31) << 20) | (32'(f7) << 25);
                end else begin
                    if (v < -2048 || v > 2047) code = 2;
                    word = base | (32'(v & 4095) << 20);
                end
            end
            7'h23: begin
                if (v < -2048 || v > 2047) code = 2;
                word = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                     | (32'(v & 31) << 7) | (32'((v >> 5) & 127) << 25);
            end
            7'h63: begin
                if (v % 2 != 0) code = 3;
                else if (v < -4096 || v > 4094) code = 2;
                word = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                     | (32'((v >> 11) & 1) << 7) | (32'((v >> 1) & 15) << 8)
                     | (32'((v >> 5) & 63) << 25) | (32'((v >> 12) & 1) << 31);
            end
            7'h6F: begin
                if (v % 2 != 0) code = 3;
                else if (v < -1048576 || v > 1048574) code = 2;
                word = 32'(op) | (32'(rd) << 7) | (32'((v >> 12) & 255) << 12)
                     | (32'((v >> 11) & 1) << 20) | (32'((v >> 1) & 1023) << 21)
                     | (32'((v >> 20) & 1) << 31);
            end
            7'h73: word = 32'h0000_0073;
            default: code = 1;
        endcase
    endfunction

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input int delay);
        int code, n;
        logic [31:0] word;
        model_enc(op, rd, rs1, rs2, f3, f7, imm, code, word);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_accept", in_ready, 1);
        drive(op, rd, rs1, rs2, f3, f7, imm);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("enc_no_wr", mem_wr_en, 0);
        check("enc_no_err", err, 0);
        check("enc_not_ready", in_ready, 0);
        tick();
        if (code != 0) begin
            m_err_code = code;
            check("err_pulse", err, 1);
            check("err_code", err_code, m_err_code);
            check("err_no_wr", mem_wr_en, 0);
            check("err_addr", mem_wr_addr, m_addr);
            check("err_count", inst_count, m_count);
            tick();
            check("err_one_cycle", err, 0);
            check("err_code_held", err_code, m_err_code);
        end else begin
            check("wr_en", mem_wr_en, 1);
            check("wr_addr", mem_wr_addr, m_addr);
            check("wr_data", mem_wr_data, word);
            for (int i = 0; i < delay; i++) begin
                tick();
                check("stall_en", mem_wr_en, 1);
                check("stall_addr", mem_wr_addr, m_addr);
                check("stall_data", mem_wr_data, word);
                check("stall_not_ready", in_ready, 0);
            end
            mem_wr_ack = 1'b1;
            tick();
            mem_wr_ack = 1'b0;
            m_count++;
            if (m_addr == 1023) m_full = 1'b1;
            else                m_addr++;
            check("post_wr_en", mem_wr_en, 0);
            check("post_wr_addr", mem_wr_addr, m_addr);
            check("post_wr_count", inst_count, m_count);
            check("post_wr_full", full, m_full);
            check("post_wr_ready", in_ready, !m_full);
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        m_addr  = 0;
        m_count = 0;
        m_full  = 1'b0;
        check("restart_ready", in_ready, 1);
        check("restart_addr", mem_wr_addr, 0);
        check("restart_count", inst_count, 0);
        check("restart_err_code_kept", err_code, m_err_code);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_ready"}, in_ready, 1);
        check({pfx, "_wr_en"}, mem_wr_en, 0);
        check({pfx, "_addr"}, mem_wr_addr, 0);
        check({pfx, "_data"}, mem_wr_data, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_err_code"}, err_code, 0);
        check({pfx, "_count"}, inst_count, 0);
        check({pfx, "_full"}, full, 0);
    endtask

    initial begin
        logic [6:0] ops [9];
        logic [6:0] op;
        logic [31:0] imm;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h73, 7'h37};

        reset = 1'b1; restart = 1'b0; in_valid = 1'b0; mem_wr_ack = 1'b0;
        drive(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        m_addr = 0; m_count = 0; m_full = 1'b0; m_err_code = 0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_state("reset");
        check("small_reset_ready", s_in_ready, 1);

        // addi x1,x0,-1 with zero-wait ack
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 0);
        check("addi_word", mem_wr_data, 32'hFFF0_0093);

        do_restart();
        // beq x1,x2,-4 with a 5-cycle ack stall, then jal x1,+2048
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 5);
        check("beq_word", mem_wr_data, 32'hFE20_8EE3);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1);
        check("jal_word", mem_wr_data, 32'h0010_00EF);

        send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4096, 0);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 0);
        send(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5001, 0);
        send(7'h13, 5'd3, 5'd4, 5'd0, 3'd5, 7'h20, 32'd31, 0);
        send(7'h13, 5'd3, 5'd4, 5'd0, 3'd1, 7'h00, 32'd32, 0);
        send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000, 0);

        // restart together with in_valid: nothing is accepted
        drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        in_valid = 1'b1;
        restart  = 1'b1;
        tick();
        in_valid = 1'b0;
        restart  = 1'b0;
        m_addr = 0; m_count = 0; m_full = 1'b0;
        check("rst_valid_ready", in_ready, 1);
        check("rst_valid_no_wr", mem_wr_en, 0);
        tick();
        check("rst_valid_still_no_wr", mem_wr_en, 0);
        check("rst_valid_no_err", err, 0);
        check("rst_valid_count", inst_count, 0);
        check("rst_valid_err_code", err_code, m_err_code);

        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = $urandom_range(0, 8191) - 32'd4096;
                2: imm = $urandom_range(0, 63) - 32'd16;
                default: imm = $urandom_range(0, 4194303) - 32'd2097152;
            endcase
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
                 imm, int'($urandom_range(0, 3)));
        end

        // Small instance: four writes fill a 4-word memory
        do_restart();
        for (int k = 0; k < 4; k++) begin
            send(7'h33, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 0);
            if (k == 2) check("small_not_full_yet", s_full, 0);
        end
        check("small_full", s_full, 1);
        check("small_full_not_ready", s_in_ready, 0);
        check("small_addr_stays", s_mem_wr_addr, 3);
        check("small_count", s_inst_count, 4);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        m_addr = 0; m_count = 0; m_full = 1'b0;
        check("small_restart_addr", s_mem_wr_addr, 0);
        check("small_restart_count", s_inst_count, 0);
        check("small_restart_full", s_full, 0);
        check("small_restart_ready", s_in_ready, 1);

        // reset during WR with a simultaneous ack
        send(7'h73, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0);
        drive(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_wr_en", mem_wr_en, 1);
        mem_wr_ack = 1'b1;
        reset      = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
        reset      = 1'b0;
        m_addr = 0; m_count = 0; m_full = 1'b0; m_err_code = 0;
        check_reset_state("mid_wr_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
